// File: rtl/sfp_port_ctrl_if.sv
// Per-channel SFP cage signals plus the software controls and status of sfp_port_ctrl.
// master drives the cage/software inputs; slave is the controller side.
interface sfp_port_ctrl_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0]    sfp_mod_abs;
  logic [CHANNELS-1:0]    sfp_los;
  logic [CHANNELS-1:0]    sfp_txfault;
  logic [CHANNELS-1:0]    rx_block_lock;
  logic [CHANNELS-1:0]    chan_enable;
  logic [CHANNELS-1:0]    fault_clear;
  logic [CHANNELS-1:0]    sfp_txdisable;
  logic [CHANNELS-1:0]    link_up;
  logic [CHANNELS-1:0]    fault_latched;
  logic [3*CHANNELS-1:0]  chan_state;
  logic [16*CHANNELS-1:0] link_drop_count;

  modport master (
    output sfp_mod_abs, sfp_los, sfp_txfault, rx_block_lock, chan_enable, fault_clear,
    input  sfp_txdisable, link_up, fault_latched, chan_state, link_drop_count
  );

  modport slave (
    input  sfp_mod_abs, sfp_los, sfp_txfault, rx_block_lock, chan_enable, fault_clear,
    output sfp_txdisable, link_up, fault_latched, chan_state, link_drop_count
  );
endinterface

// File: rtl/sfp_port_ctrl.sv
// SFP cage controller: synchronised/debounced cage inputs feed one bring-up FSM per channel
// with TX init wait, fault retry and lockout. Macro SFP_PORT_CTRL_STATS_EN adds link drop counters.
module sfp_port_ctrl #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 156250,
  parameter int TX_INIT_CYCLES  = 46875,
  parameter int RETRY_CYCLES    = 1562500,
  parameter int MAX_RETRIES     = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  sfp_port_ctrl_if.slave sfp_bus
);
  localparam int TMAX = (TX_INIT_CYCLES > RETRY_CYCLES) ? TX_INIT_CYCLES : RETRY_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0]  TX_INIT_T  = TW'(TX_INIT_CYCLES);
  localparam logic [TW-1:0]  RETRY_LAST = TW'(RETRY_CYCLES - 1);
  // Bit order {mod_abs, los, txfault, block_lock}: absent, no signal, no fault, no lock.
  localparam logic [3:0]     SYNC_RST   = 4'b1100;

  typedef enum logic [2:0] {
    ST_ABSENT  = 3'd0,
    ST_OFF     = 3'd1,
    ST_TX_WAIT = 3'd2,
    ST_UP      = 3'd3,
    ST_FAULT   = 3'd4,
    ST_LOCKOUT = 3'd5
  } state_t;

  logic [CHANNELS-1:0]    w_txdis;
  logic [CHANNELS-1:0]    w_link;
  logic [CHANNELS-1:0]    w_flt;
  logic [3*CHANNELS-1:0]  w_state_vec;
  logic [16*CHANNELS-1:0] w_drop_vec;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    logic [3:0]     w_raw;
    logic [3:0]     r_sync1;
    logic [3:0]     r_sync2;
    logic [3:0]     r_filt;
    logic [DBW-1:0] r_db_cnt [4];
    state_t         r_state;
    state_t         w_state_next;
    logic [TW-1:0]  r_timer;
    logic [3:0]     r_retry;
    logic           r_txdis;
    logic           r_link;
    logic           r_flt;
    logic           w_clear;
    logic           w_fault_entry;
    logic           w_abs, w_los, w_txf, w_lock;

    assign w_raw = {sfp_bus.sfp_mod_abs[gi], sfp_bus.sfp_los[gi],
                    sfp_bus.sfp_txfault[gi], sfp_bus.rx_block_lock[gi]};
    assign {w_abs, w_los, w_txf, w_lock} = r_filt;

    // Filtered bit follows only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync1 <= SYNC_RST;
        r_sync2 <= SYNC_RST;
        r_filt  <= SYNC_RST;
        for (int b = 0; b < 4; b++) r_db_cnt[b] <= '0;
      end else begin
        r_sync1 <= w_raw;
        r_sync2 <= r_sync1;
        for (int b = 0; b < 4; b++) begin
          if (r_sync2[b] == r_filt[b]) begin
            r_db_cnt[b] <= '0;
          end else if (r_db_cnt[b] == DB_LAST) begin
            r_filt[b]   <= r_sync2[b];
            r_db_cnt[b] <= '0;
          end else begin
            r_db_cnt[b] <= r_db_cnt[b] + 1'b1;
          end
        end
      end
    end

    always_comb begin
      w_state_next = r_state;
      w_clear      = 1'b0;
      if (w_abs) begin
        w_state_next = ST_ABSENT;
      end else if (sfp_bus.fault_clear[gi]) begin
        w_state_next = ST_OFF;
        w_clear      = 1'b1;
      end else if (!sfp_bus.chan_enable[gi] && r_state != ST_LOCKOUT) begin
        w_state_next = ST_OFF;
      end else begin
        case (r_state)
          ST_ABSENT: w_state_next = ST_OFF;
          ST_OFF:    w_state_next = ST_TX_WAIT;
          // txfault is meaningless until the module's TX init time has elapsed.
          ST_TX_WAIT: begin
            if (r_timer == TX_INIT_T) begin
              if (w_txf)                w_state_next = ST_FAULT;
              else if (!w_los && w_lock) w_state_next = ST_UP;
            end
          end
          ST_UP: begin
            if (w_txf)                 w_state_next = ST_FAULT;
            else if (w_los || !w_lock) w_state_next = ST_TX_WAIT;
          end
          ST_FAULT: begin
            if (r_timer == RETRY_LAST)
              w_state_next = (int'(r_retry) <= MAX_RETRIES) ? ST_TX_WAIT : ST_LOCKOUT;
          end
          default: w_state_next = r_state;
        endcase
      end
    end

    assign w_fault_entry = (w_state_next == ST_FAULT) && (r_state != ST_FAULT);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= ST_ABSENT;
        r_timer <= '0;
        r_retry <= '0;
        r_txdis <= 1'b1;
        r_link  <= 1'b0;
        r_flt   <= 1'b0;
      end else begin
        r_state <= w_state_next;
        r_txdis <= !(w_state_next == ST_TX_WAIT || w_state_next == ST_UP);
        r_link  <= (w_state_next == ST_UP);
        if (w_state_next != r_state)
          r_timer <= '0;
        else if ((r_state == ST_TX_WAIT && r_timer != TX_INIT_T) ||
                 (r_state == ST_FAULT && r_timer != RETRY_LAST))
          r_timer <= r_timer + 1'b1;
        if (w_clear || w_state_next == ST_ABSENT || w_state_next == ST_UP)
          r_retry <= '0;
        else if (w_fault_entry && r_retry != 4'hF)
          r_retry <= r_retry + 4'd1;
        if (w_clear)            r_flt <= 1'b0;
        else if (w_fault_entry) r_flt <= 1'b1;
      end
    end

    assign w_txdis[gi]           = r_txdis;
    assign w_link[gi]            = r_link;
    assign w_flt[gi]             = r_flt;
    assign w_state_vec[gi*3 +: 3] = r_state;

`ifdef SFP_PORT_CTRL_STATS_EN
    logic        w_drop;
    logic [15:0] r_drop_cnt;

    assign w_drop = (r_state == ST_UP) && (w_state_next == ST_TX_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             r_drop_cnt <= '0;
      else if (w_clear)                       r_drop_cnt <= '0;
      else if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end

    assign w_drop_vec[gi*16 +: 16] = r_drop_cnt;
`else
    assign w_drop_vec[gi*16 +: 16] = 16'd0;
`endif
  end

  assign sfp_bus.sfp_txdisable   = w_txdis;
  assign sfp_bus.link_up         = w_link;
  assign sfp_bus.fault_latched   = w_flt;
  assign sfp_bus.chan_state      = w_state_vec;
  assign sfp_bus.link_drop_count = w_drop_vec;
endmodule
